up_bus_combiner: RTL and testbench

- Parametrised response/status combiner for ADC cores: replaces the fixed 4-way OR of up_rdata/up_rack/up_wack and the 2-channel status OR in each core top.
- Scales to NUM_SLAVES register slaves and NUM_CHANNELS channels, with per-channel status masking.
- Adds bus-error detection (multi-ack collision, unsolicited ack) and an optional access-timeout responder.
- Sits between up_axi and the up_* register slaves (channels, up_adc_common, up_delay_cntrl).

---
 rtl/up_bus_combiner.sv | 195 +++++++++++++++++++
 tb/tb_up_bus_combiner.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_bus_combiner.sv
// up_bus_combiner: parametrised up-bus ack/rdata combiner with collision flags and masked ADC status ORs.
// Define UP_BUS_TIMEOUT_EN to add per-direction access-timeout responders and unsolicited-ack filtering.

`ifdef UP_BUS_TIMEOUT_EN
module up_bus_req_fsm #(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic up_clk,
    input  logic up_rstn,
    input  logic req,
    input  logic ack,
    output logic fwd,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, TIMEOUT} state_t;

    state_t state, state_next;
    logic [CW-1:0] cnt, cnt_next;

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A slave ack in WAIT wins over a timeout due in the same cycle; a new req restarts the wait.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        fwd        = 1'b0;
        timeout    = 1'b0;
        case (state)
            WAIT: begin
                if (ack) begin
                    fwd        = 1'b1;
                    state_next = req ? WAIT : IDLE;
                    cnt_next   = '0;
                end else if (req) begin
                    cnt_next = '0;
                end else if (cnt == LAST) begin
                    timeout    = 1'b1;
                    state_next = TIMEOUT;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                if (req) begin
                    state_next = WAIT;
                    cnt_next   = '0;
                end else begin
                    state_next = IDLE;
                end
            end
        endcase
    end

endmodule
`endif

module up_bus_combiner #(
    parameter int          NUM_SLAVES     = 4,
    parameter int          NUM_CHANNELS   = 2,
    parameter int          TIMEOUT_CYCLES = 32,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADDEAD
) (
    input  logic                      up_clk,
    input  logic                      up_rstn,
    input  logic                      up_rreq,
    input  logic                      up_wreq,
    input  logic [32*NUM_SLAVES-1:0]  up_slv_rdata,
    input  logic [NUM_SLAVES-1:0]     up_slv_rack,
    input  logic [NUM_SLAVES-1:0]     up_slv_wack,
    output logic [31:0]               up_rdata,
    output logic                      up_rack,
    output logic                      up_wack,
    input  logic [NUM_CHANNELS-1:0]   up_ch_mask,
    input  logic [NUM_CHANNELS-1:0]   up_ch_pn_err,
    input  logic [NUM_CHANNELS-1:0]   up_ch_pn_oos,
    input  logic [NUM_CHANNELS-1:0]   up_ch_or,
    output logic                      up_status_pn_err,
    output logic                      up_status_pn_oos,
    output logic                      up_status_or,
    input  logic                      up_clr,
    output logic [2:0]                up_bus_err,
    output logic [15:0]               up_timeout_cnt
);

    localparam logic [NUM_SLAVES-1:0] ONE = NUM_SLAVES'(1);

    logic [31:0] slv_rdata_or;
    logic        rack_any, wack_any, rd_coll, wr_coll;
    logic        rd_fwd, rd_timeout, wr_fwd, wr_timeout, unsolicited;

    always_comb begin
        slv_rdata_or = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            slv_rdata_or = slv_rdata_or | up_slv_rdata[32*k +: 32];
        end
    end

    // Clearing the lowest set bit leaves something only when two or more acks are high.
    assign rack_any = |up_slv_rack;
    assign wack_any = |up_slv_wack;
    assign rd_coll  = |(up_slv_rack & (up_slv_rack - ONE));
    assign wr_coll  = |(up_slv_wack & (up_slv_wack - ONE));

`ifdef UP_BUS_TIMEOUT_EN
    logic [16:0] timeout_sum;

    up_bus_req_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) rd_fsm (
        .up_clk  (up_clk),
        .up_rstn (up_rstn),
        .req     (up_rreq),
        .ack     (rack_any),
        .fwd     (rd_fwd),
        .timeout (rd_timeout)
    );

    up_bus_req_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) wr_fsm (
        .up_clk  (up_clk),
        .up_rstn (up_rstn),
        .req     (up_wreq),
        .ack     (wack_any),
        .fwd     (wr_fwd),
        .timeout (wr_timeout)
    );

    assign unsolicited = (rack_any & ~rd_fwd) | (wack_any & ~wr_fwd);
    assign timeout_sum = {1'b0, up_timeout_cnt} + 17'(rd_timeout) + 17'(wr_timeout);

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            up_timeout_cnt <= '0;
        end else if (up_clr) begin
            up_timeout_cnt <= '0;
        end else begin
            up_timeout_cnt <= timeout_sum[16] ? 16'hFFFF : timeout_sum[15:0];
        end
    end
`else
    logic unused_cfg;

    assign rd_fwd         = rack_any;
    assign wr_fwd         = wack_any;
    assign rd_timeout     = 1'b0;
    assign wr_timeout     = 1'b0;
    assign unsolicited    = 1'b0;
    assign up_timeout_cnt = '0;
    assign unused_cfg     = ^{up_rreq, up_wreq, 32'(TIMEOUT_CYCLES)};
`endif

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            up_rack  <= 1'b0;
            up_wack  <= 1'b0;
            up_rdata <= '0;
        end else begin
            up_rack  <= rd_fwd | rd_timeout;
            up_wack  <= wr_fwd | wr_timeout;
            up_rdata <= rd_fwd ? slv_rdata_or : (rd_timeout ? TIMEOUT_DATA : 32'h0);
        end
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            up_bus_err <= '0;
        end else if (up_clr) begin
            up_bus_err <= '0;
        end else begin
            up_bus_err <= up_bus_err | {unsolicited, wr_coll, rd_coll};
        end
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            up_status_pn_err <= 1'b0;
            up_status_pn_oos <= 1'b0;
            up_status_or     <= 1'b0;
        end else begin
            up_status_pn_err <= |(up_ch_pn_err & up_ch_mask);
            up_status_pn_oos <= |(up_ch_pn_oos & up_ch_mask);
            up_status_or     <= |(up_ch_or & up_ch_mask);
        end
    end

endmodule

// File: tb/tb_up_bus_combiner.sv
// tb_up_bus_combiner: directed test-plan scenarios plus random traffic checked every cycle
// against a cycle-numbered request/deadline model of the combiner.

module tb_up_bus_combiner;

    localparam int          NS = 4;
    localparam int          NC = 2;
    localparam int          TO = 32;
    localparam logic [31:0] TD = 32'hDEADDEAD;

    logic              up_clk;
    logic              up_rstn;
    logic              up_rreq, up_wreq;
    logic [32*NS-1:0]  up_slv_rdata;
    logic [NS-1:0]     up_slv_rack, up_slv_wack;
    logic [31:0]       up_rdata;
    logic              up_rack, up_wack;
    logic [NC-1:0]     up_ch_mask, up_ch_pn_err, up_ch_pn_oos, up_ch_or;
    logic              up_status_pn_err, up_status_pn_oos, up_status_or;
    logic              up_clr;
    logic [2:0]        up_bus_err;
    logic [15:0]       up_timeout_cnt;

    up_bus_combiner #(
        .NUM_SLAVES     (NS),
        .NUM_CHANNELS   (NC),
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_DATA   (TD)
    ) dut (
        .up_clk           (up_clk),
        .up_rstn          (up_rstn),
        .up_rreq          (up_rreq),
        .up_wreq          (up_wreq),
        .up_slv_rdata     (up_slv_rdata),
        .up_slv_rack      (up_slv_rack),
        .up_slv_wack      (up_slv_wack),
        .up_rdata         (up_rdata),
        .up_rack          (up_rack),
        .up_wack          (up_wack),
        .up_ch_mask       (up_ch_mask),
        .up_ch_pn_err     (up_ch_pn_err),
        .up_ch_pn_oos     (up_ch_pn_oos),
        .up_ch_or         (up_ch_or),
        .up_status_pn_err (up_status_pn_err),
        .up_status_pn_oos (up_status_pn_oos),
        .up_status_or     (up_status_or),
        .up_clr           (up_clr),
        .up_bus_err       (up_bus_err),
        .up_timeout_cnt   (up_timeout_cnt)
    );

    initial up_clk = 1'b0;
    always #5 up_clk = ~up_clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          rd_pend = 0, wr_pend = 0;
    int          rd_t = 0, wr_t = 0;
    logic        e_rack = 0, e_wack = 0;
    logic [31:0] e_rdata = 0;
    logic [2:0]  e_err = 0, e_status = 0;
    logic [15:0] e_tcnt = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit multi_hot(input logic [NS-1:0] v);
        int n = 0;
        for (int k = 0; k < NS; k++) n += int'(v[k]);
        return n > 1;
    endfunction

    // One direction of the reference: a request opens a window of TO cycles for a slave ack.
    task automatic dirStep(inout bit pend, inout int t, input bit req, input bit any,
                           output bit acc, output bit tmo);
        acc = 0;
        tmo = 0;
        if (pend && any) begin
            acc  = 1;
            pend = req;
            t    = cyc;
        end else if (pend && req) begin
            t = cyc;
        end else if (pend && cyc == t + TO) begin
            tmo  = 1;
            pend = 0;
        end else if (req) begin
            pend = 1;
            t    = cyc;
        end
    endtask

    task automatic modelStep();
        logic [31:0] ord;
        bit r_acc, r_tmo, w_acc, w_tmo, unsol;
        int sum;
        if (!up_rstn) begin
            rd_pend = 0; wr_pend = 0;
            e_rack = 0; e_wack = 0; e_rdata = 0;
            e_err = 0; e_tcnt = 0; e_status = 0;
            cyc++;
            return;
        end
        ord = 0;
        for (int k = 0; k < NS; k++) ord |= up_slv_rdata[32*k +: 32];
`ifdef UP_BUS_TIMEOUT_EN
        dirStep(rd_pend, rd_t, up_rreq, |up_slv_rack, r_acc, r_tmo);
        dirStep(wr_pend, wr_t, up_wreq, |up_slv_wack, w_acc, w_tmo);
        unsol = ((|up_slv_rack) && !r_acc) || ((|up_slv_wack) && !w_acc);
`else
        r_acc = |up_slv_rack; r_tmo = 0;
        w_acc = |up_slv_wack; w_tmo = 0;
        unsol = 0;
`endif
        e_rack  = r_acc | r_tmo;
        e_wack  = w_acc | w_tmo;
        e_rdata = r_acc ? ord : (r_tmo ? TD : 32'h0);
        if (up_clr) begin
            e_err  = 0;
            e_tcnt = 0;
        end else begin
            e_err = e_err | {unsol, multi_hot(up_slv_wack), multi_hot(up_slv_rack)};
            sum   = int'(e_tcnt) + int'(r_tmo) + int'(w_tmo);
            e_tcnt = (sum > 65535) ? 16'hFFFF : 16'(sum);
        end
        e_status = {|(up_ch_or & up_ch_mask), |(up_ch_pn_oos & up_ch_mask), |(up_ch_pn_err & up_ch_mask)};
        cyc++;
    endtask

    task automatic cycleAndCheck();
        modelStep();
        @(posedge up_clk);
        #1;
        checkOutput("rack", 32'(up_rack), 32'(e_rack));
        checkOutput("wack", 32'(up_wack), 32'(e_wack));
        checkOutput("rdata", up_rdata, e_rdata);
        checkOutput("bus_err", 32'(up_bus_err), 32'(e_err));
        checkOutput("timeout_cnt", 32'(up_timeout_cnt), 32'(e_tcnt));
        checkOutput("status", 32'({up_status_or, up_status_pn_oos, up_status_pn_err}), 32'(e_status));
    endtask

    task automatic applyStimulus(input bit rreq, input bit wreq, input logic [NS-1:0] rack,
                                 input logic [NS-1:0] wack, input bit clr);
        @(negedge up_clk);
        up_rreq     = rreq;
        up_wreq     = wreq;
        up_slv_rack = rack;
        up_slv_wack = wack;
        up_clr      = clr;
        cycleAndCheck();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0);
    endtask

    function automatic logic [NS-1:0] randAck();
        int r = $urandom_range(0, 19);
        if (r == 0) return NS'(1) << $urandom_range(0, NS - 1);
        if (r == 1) return NS'($urandom_range(1, (1 << NS) - 1));
        return '0;
    endfunction

    initial begin
        up_rstn = 0;
        up_rreq = 0; up_wreq = 0; up_clr = 0;
        up_slv_rdata = '0; up_slv_rack = '0; up_slv_wack = '0;
        up_ch_mask = '0; up_ch_pn_err = '0; up_ch_pn_oos = '0; up_ch_or = '0;

        $display("[TB] reset");
        idle(3);
        checkOutput("reset_err", 32'(up_bus_err), 32'h0);
        @(negedge up_clk);
        up_rstn = 1;
        idle(2);

        $display("[TB] normal read");
        applyStimulus(1, 0, '0, '0, 0);
        up_slv_rdata[32*2 +: 32] = 32'h12345678;
        applyStimulus(0, 0, 4'b0100, '0, 0);
        checkOutput("read_rack", 32'(up_rack), 32'h1);
        checkOutput("read_data", up_rdata, 32'h12345678);
        checkOutput("read_err", 32'(up_bus_err), 32'h0);
        up_slv_rdata = '0;
        idle(2);

        $display("[TB] read timeout");
        applyStimulus(1, 0, '0, '0, 0);
        idle(31);
        checkOutput("tmo_early", 32'(up_rack), 32'h0);
        idle(1);
`ifdef UP_BUS_TIMEOUT_EN
        checkOutput("tmo_rack", 32'(up_rack), 32'h1);
        checkOutput("tmo_data", up_rdata, TD);
        checkOutput("tmo_cnt", 32'(up_timeout_cnt), 32'h1);
`else
        checkOutput("tmo_rack", 32'(up_rack), 32'h0);
        checkOutput("tmo_cnt", 32'(up_timeout_cnt), 32'h0);
`endif
        idle(2);

        $display("[TB] ack on the last wait cycle");
        applyStimulus(1, 0, '0, '0, 0);
        idle(31);
        up_slv_rdata[32*1 +: 32] = 32'hA5A55A5A;
        applyStimulus(0, 0, 4'b0010, '0, 0);
        up_slv_rdata = '0;
        checkOutput("bound_rack", 32'(up_rack), 32'h1);
        checkOutput("bound_data", up_rdata, 32'hA5A55A5A);
`ifdef UP_BUS_TIMEOUT_EN
        checkOutput("bound_cnt", 32'(up_timeout_cnt), 32'h1);
`else
        checkOutput("bound_cnt", 32'(up_timeout_cnt), 32'h0);
`endif
        idle(3);

        $display("[TB] write collision");
        applyStimulus(0, 0, '0, '0, 1);
        applyStimulus(0, 1, '0, '0, 0);
        applyStimulus(0, 0, '0, 4'b1001, 0);
        checkOutput("coll_wack", 32'(up_wack), 32'h1);
        checkOutput("coll_err", 32'(up_bus_err), 32'h2);
        idle(1);
        checkOutput("coll_wack_single", 32'(up_wack), 32'h0);
        applyStimulus(0, 0, '0, '0, 1);
        checkOutput("coll_clr", 32'(up_bus_err), 32'h0);

        $display("[TB] unsolicited ack");
        applyStimulus(0, 0, 4'b0010, '0, 0);
`ifdef UP_BUS_TIMEOUT_EN
        checkOutput("unsol_rack", 32'(up_rack), 32'h0);
        checkOutput("unsol_err", 32'(up_bus_err), 32'h4);
`else
        checkOutput("unsol_rack", 32'(up_rack), 32'h1);
        checkOutput("unsol_err", 32'(up_bus_err), 32'h0);
`endif
        applyStimulus(0, 0, '0, '0, 1);

        $display("[TB] request restart");
        applyStimulus(0, 1, '0, '0, 0);
        idle(19);
        applyStimulus(0, 1, '0, '0, 0);
        idle(31);
        checkOutput("restart_early", 32'(up_wack), 32'h0);
        idle(1);
`ifdef UP_BUS_TIMEOUT_EN
        checkOutput("restart_wack", 32'(up_wack), 32'h1);
`else
        checkOutput("restart_wack", 32'(up_wack), 32'h0);
`endif
        idle(2);

        $display("[TB] status mask");
        up_ch_pn_err = 2'b10;
        up_ch_mask   = 2'b01;
        idle(1);
        checkOutput("mask_off", 32'(up_status_pn_err), 32'h0);
        up_ch_mask = 2'b11;
        idle(1);
        checkOutput("mask_on", 32'(up_status_pn_err), 32'h1);

        $display("[TB] reset during access");
        applyStimulus(1, 1, '0, '0, 0);
        idle(5);
        @(negedge up_clk);
        up_rstn = 0;
        cycleAndCheck();
        cycleAndCheck();
        @(negedge up_clk);
        up_rstn = 1;
        cycleAndCheck();
        idle(40);
        checkOutput("rst_cnt", 32'(up_timeout_cnt), 32'h0);

        $display("[TB] random traffic");
        for (int i = 0; i < 2500; i++) begin
            @(negedge up_clk);
            up_rreq     = !rd_pend && ($urandom_range(0, 9) == 0);
            up_wreq     = !wr_pend && ($urandom_range(0, 9) == 0);
            up_slv_rack = randAck();
            up_slv_wack = randAck();
            for (int k = 0; k < NS; k++) up_slv_rdata[32*k +: 32] = $urandom();
            up_clr       = ($urandom_range(0, 39) == 0);
            up_ch_mask   = NC'($urandom_range(0, 3));
            up_ch_pn_err = NC'($urandom_range(0, 3));
            up_ch_pn_oos = NC'($urandom_range(0, 3));
            up_ch_or     = NC'($urandom_range(0, 3));
            cycleAndCheck();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
